// File: rtl/hack_boot_loader_pkg.sv
// Shared definitions for the Hack boot loader: state encodings, defaults and
// state-class helpers used by the FSM and the idle timer control.
package hack_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_WRITE   = 3'd5,
    ST_RUN     = 3'd6,
    ST_ERR     = 3'd7
  } boot_state_e;

  localparam logic [7:0]  BOOT_MAGIC_DEFAULT   = 8'hA5;
  localparam int unsigned BOOT_TIMEOUT_DEFAULT = 1000000;

  function automatic logic accepts_bytes(input boot_state_e s);
    return s inside {ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO};
  endfunction

  // Only mid-image states are guarded against a stalled sender.
  function automatic logic timed_state(input boot_state_e s);
    return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO};
  endfunction

endpackage

// File: rtl/hack_boot_loader_timer.sv
// Idle-cycle counter: counts enabled cycles, saturates at TIMEOUT_CYC and
// flags expiry; clear has priority over enable.
module boot_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] count_q, count_d;

  assign expired_o = (count_q >= LIMIT);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/hack_boot_loader.sv
// Boot sequencer: receives MAGIC, 16-bit length and data bytes, writes words
// from address 0, then releases the CPU; malformed or stalled images trap in ERR.
module hack_boot_loader
  import hack_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned DEPTH       = 32768,
  parameter logic [7:0]  MAGIC       = BOOT_MAGIC_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = BOOT_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              reload,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              loading,
  output logic              done,
  output logic              error
);

  boot_state_e       state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       words_q, words_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              accept;
  logic              tmo_expired;
  logic [15:0]       len_cat;
  logic [15:0]       words_inc;

  assign byte_ready = reset && accepts_bytes(state_q) && !reload;
  assign accept     = byte_valid && byte_ready;
  assign len_cat    = {len_q[15:8], byte_data};
  assign words_inc  = words_q + 16'd1;

  assign rom_we    = (state_q == ST_WRITE) && !reload;
  assign rom_addr  = addr_q;
  assign rom_wdata = wdata_q;
  assign cpu_reset = (state_q != ST_RUN);
  assign loading   = (state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_WRITE});
  assign done      = (state_q == ST_RUN);
  assign error     = (state_q == ST_ERR);

  boot_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk_i    (clk),
    .rst_ni   (reset),
    .clear_i  (!timed_state(state_q) || accept || reload),
    .enable_i (timed_state(state_q) && !accept),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    words_d = words_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (reload) begin
      state_d = ST_IDLE;
      len_d   = '0;
      words_d = '0;
      addr_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (accept && byte_data == MAGIC) state_d = ST_LEN_HI;
        ST_LEN_HI:  if (accept) begin
                      len_d[15:8] = byte_data;
                      state_d     = ST_LEN_LO;
                    end
        ST_LEN_LO:  if (accept) begin
                      len_d   = len_cat;
                      addr_d  = '0;
                      words_d = '0;
                      state_d = (len_cat == 16'd0 || 32'(len_cat) > DEPTH) ? ST_ERR : ST_DATA_HI;
                    end
        ST_DATA_HI: if (accept) begin
                      hi_d    = byte_data;
                      state_d = ST_DATA_LO;
                    end
        ST_DATA_LO: if (accept) begin
                      wdata_d = {hi_q, byte_data};
                      state_d = ST_WRITE;
                    end
        ST_WRITE:   begin
                      words_d = words_inc;
                      if (words_inc == len_q) begin
                        state_d = ST_RUN;
                      end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_DATA_HI;
                      end
                    end
        default:    state_d = state_q;
      endcase
      // A byte arriving in the expiry cycle still wins over the timeout.
      if (timed_state(state_q) && !accept && tmo_expired) state_d = ST_ERR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      words_q <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      words_q <= words_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
